// File: rtl/alu_arbiter_if.sv
// Request, ALU and response signals of the two-requester ALU arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding environment's view.
interface alu_arbiter_if #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 3
);
  logic              Req0Valid;
  logic              Req0Ready;
  logic [WIDTH-1:0]  Req0A;
  logic [WIDTH-1:0]  Req0B;
  logic [CTRL_W-1:0] Req0Ctrl;
  logic              Req1Valid;
  logic              Req1Ready;
  logic [WIDTH-1:0]  Req1A;
  logic [WIDTH-1:0]  Req1B;
  logic [CTRL_W-1:0] Req1Ctrl;
  logic [WIDTH-1:0]  AluA;
  logic [WIDTH-1:0]  AluB;
  logic [CTRL_W-1:0] AluControl;
  logic [WIDTH-1:0]  AluResult;
  logic              AluZero;
  logic              RspValid;
  logic              RspReady;
  logic              RspId;
  logic [WIDTH-1:0]  RspResult;
  logic              RspZero;

  modport slave (
    input  Req0Valid, Req0A, Req0B, Req0Ctrl,
    input  Req1Valid, Req1A, Req1B, Req1Ctrl,
    input  AluResult, AluZero, RspReady,
    output Req0Ready, Req1Ready,
    output AluA, AluB, AluControl,
    output RspValid, RspId, RspResult, RspZero
  );

  modport master (
    output Req0Valid, Req0A, Req0B, Req0Ctrl,
    output Req1Valid, Req1A, Req1B, Req1Ctrl,
    output AluResult, AluZero, RspReady,
    input  Req0Ready, Req1Ready,
    input  AluA, AluB, AluControl,
    input  RspValid, RspId, RspResult, RspZero
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external ALU between two requesters,
// with a registered issue stage feeding the ALU and a registered result stage.
module alu_arbiter #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 3
) (
  input logic         clk,
  input logic         rst_n,
  alu_arbiter_if.slave bus
);

  logic              iss_valid_q, iss_valid_d;
  logic [WIDTH-1:0]  iss_a_q, iss_a_d;
  logic [WIDTH-1:0]  iss_b_q, iss_b_d;
  logic [CTRL_W-1:0] iss_ctrl_q, iss_ctrl_d;
  logic              iss_id_q, iss_id_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]  rsp_result_q, rsp_result_d;
  logic              rsp_zero_q, rsp_zero_d;
  logic              last_grant_q, last_grant_d;

  logic win0_s, win1_s;
  logic ready0_s, ready1_s, accept_s;
  logic rsp_free_s, iss_adv_s, iss_free_s;

  assign rsp_free_s = ~rsp_valid_q | bus.RspReady;
  assign iss_adv_s  = iss_valid_q & rsp_free_s;
  assign iss_free_s = ~iss_valid_q | iss_adv_s;

  // Winner selection: a lone requester wins; on contention the one not granted last wins.
  always_comb begin
    win0_s = 1'b0;
    win1_s = 1'b0;
    if (bus.Req0Valid && bus.Req1Valid) begin
      win0_s = last_grant_q;
      win1_s = ~last_grant_q;
    end else begin
      win0_s = bus.Req0Valid;
      win1_s = bus.Req1Valid;
    end
  end

  // Ready is held low throughout reset so nothing is accepted while the stages are cleared.
  assign ready0_s      = rst_n & win0_s & iss_free_s;
  assign ready1_s      = rst_n & win1_s & iss_free_s;
  assign accept_s      = ready0_s | ready1_s;
  assign bus.Req0Ready = ready0_s;
  assign bus.Req1Ready = ready1_s;

  // Next-state for the issue stage, the result stage and the round-robin pointer.
  always_comb begin
    iss_valid_d  = iss_valid_q;
    iss_a_d      = iss_a_q;
    iss_b_d      = iss_b_q;
    iss_ctrl_d   = iss_ctrl_q;
    iss_id_d     = iss_id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    last_grant_d = last_grant_q;

    if (accept_s) begin
      iss_valid_d  = 1'b1;
      iss_id_d     = ready1_s;
      last_grant_d = ready1_s;
      if (ready1_s) begin
        iss_a_d    = bus.Req1A;
        iss_b_d    = bus.Req1B;
        iss_ctrl_d = bus.Req1Ctrl;
      end else begin
        iss_a_d    = bus.Req0A;
        iss_b_d    = bus.Req0B;
        iss_ctrl_d = bus.Req0Ctrl;
      end
    end else if (iss_adv_s) begin
      iss_valid_d = 1'b0;
    end else begin
      iss_valid_d = iss_valid_q;
    end

    // The ALU output belongs to the operation currently in the issue stage.
    if (iss_adv_s) begin
      rsp_valid_d  = 1'b1;
      rsp_id_d     = iss_id_q;
      rsp_result_d = bus.AluResult;
      rsp_zero_d   = bus.AluZero;
    end else if (bus.RspReady) begin
      rsp_valid_d = 1'b0;
    end else begin
      rsp_valid_d = rsp_valid_q;
    end
  end

  // Pipeline and arbitration state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_valid_q  <= 1'b0;
      iss_a_q      <= {WIDTH{1'b0}};
      iss_b_q      <= {WIDTH{1'b0}};
      iss_ctrl_q   <= {CTRL_W{1'b0}};
      iss_id_q     <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= {WIDTH{1'b0}};
      rsp_zero_q   <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      iss_valid_q  <= iss_valid_d;
      iss_a_q      <= iss_a_d;
      iss_b_q      <= iss_b_d;
      iss_ctrl_q   <= iss_ctrl_d;
      iss_id_q     <= iss_id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign bus.AluA       = iss_a_q;
  assign bus.AluB       = iss_b_q;
  assign bus.AluControl = iss_ctrl_q;
  assign bus.RspValid   = rsp_valid_q;
  assign bus.RspId      = rsp_id_q;
  assign bus.RspResult  = rsp_result_q;
  assign bus.RspZero    = rsp_zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a behavioural model of the external ALU.
module tb_alu_arbiter;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_acc;

  alu_arbiter_if #(.WIDTH(32), .CTRL_W(3)) bus ();

  alu_arbiter #(.WIDTH(32), .CTRL_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU: 010 ADD, 110 SUB, 000 AND, 001 OR, anything else XOR.
  always_comb begin
    logic [31:0] res;
    case (bus.AluControl)
      3'b010:  res = bus.AluA + bus.AluB;
      3'b110:  res = bus.AluA - bus.AluB;
      3'b000:  res = bus.AluA & bus.AluB;
      3'b001:  res = bus.AluA | bus.AluB;
      default: res = bus.AluA ^ bus.AluB;
    endcase
    bus.AluResult = res;
    bus.AluZero   = (res == 32'd0);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic chk_rsp(input string tag, input logic id, input logic [31:0] res, input logic zero);
    check_eq({tag, "_valid"}, {31'd0, bus.RspValid}, 32'd1);
    check_eq({tag, "_id"}, {31'd0, bus.RspId}, {31'd0, id});
    check_eq({tag, "_result"}, bus.RspResult, res);
    check_eq({tag, "_zero"}, {31'd0, bus.RspZero}, {31'd0, zero});
  endtask

  task automatic drive0(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
    bus.Req0Valid = v; bus.Req0A = a; bus.Req0B = b; bus.Req0Ctrl = c;
  endtask

  task automatic drive1(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
    bus.Req1Valid = v; bus.Req1A = a; bus.Req1B = b; bus.Req1Ctrl = c;
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.RspReady = 1'b1;
    drive0(1'b1, 32'h5, 32'h6, 3'b010);
    drive1(1'b1, 32'h7, 32'h8, 3'b010);

    // Reset state, with both requesters asserting valid.
    repeat (2) @(posedge clk);
    mid();
    check_eq("rst_ready0", {31'd0, bus.Req0Ready}, 32'd0);
    check_eq("rst_ready1", {31'd0, bus.Req1Ready}, 32'd0);
    check_eq("rst_rspvalid", {31'd0, bus.RspValid}, 32'd0);
    check_eq("rst_rspid", {31'd0, bus.RspId}, 32'd0);
    check_eq("rst_rspresult", bus.RspResult, 32'd0);
    check_eq("rst_rspzero", {31'd0, bus.RspZero}, 32'd0);
    check_eq("rst_alua", bus.AluA, 32'd0);
    check_eq("rst_alub", bus.AluB, 32'd0);
    check_eq("rst_aluctrl", {29'd0, bus.AluControl}, 32'd0);
    next_cycle();
    drive0(1'b0, 32'd0, 32'd0, 3'b000);
    drive1(1'b0, 32'd0, 32'd0, 3'b000);
    rst_n = 1'b1;
    next_cycle();

    // Single ADD from requester 0.
    drive0(1'b1, 32'h0000_1345, 32'h0000_C134, 3'b010);
    mid();
    check_eq("t1_ready0", {31'd0, bus.Req0Ready}, 32'd1);
    next_cycle();
    drive0(1'b0, 32'd0, 32'd0, 3'b000);
    mid();
    check_eq("t1_notyet", {31'd0, bus.RspValid}, 32'd0);
    check_eq("t1_alua", bus.AluA, 32'h0000_1345);
    check_eq("t1_aluctrl", {29'd0, bus.AluControl}, 32'd2);
    next_cycle();
    mid();
    chk_rsp("t1", 1'b0, 32'h0000_D479, 1'b0);
    next_cycle();
    mid();
    check_eq("t1_drained", {31'd0, bus.RspValid}, 32'd0);
    next_cycle();

    // Single SUB from requester 1 giving zero.
    drive1(1'b1, 32'h0000_1345, 32'h0000_1345, 3'b110);
    mid();
    check_eq("t2_ready1", {31'd0, bus.Req1Ready}, 32'd1);
    check_eq("t2_ready0", {31'd0, bus.Req0Ready}, 32'd0);
    next_cycle();
    drive1(1'b0, 32'd0, 32'd0, 3'b000);
    next_cycle();
    mid();
    chk_rsp("t2", 1'b1, 32'd0, 1'b1);
    next_cycle();
    next_cycle();

    // Contention for 4 cycles: grants and responses alternate 0,1,0,1.
    for (int c = 0; c < 6; c++) begin
      drive0(c < 4, 32'd1, 32'd1, 3'b010);
      drive1(c < 4, 32'd10, 32'd3, 3'b110);
      mid();
      if (c < 4) begin
        check_eq($sformatf("t3_ready0_c%0d", c), {31'd0, bus.Req0Ready}, (c % 2 == 0) ? 32'd1 : 32'd0);
        check_eq($sformatf("t3_ready1_c%0d", c), {31'd0, bus.Req1Ready}, (c % 2 == 1) ? 32'd1 : 32'd0);
      end
      if (c >= 2) begin
        if ((c - 2) % 2 == 0) chk_rsp($sformatf("t3_rsp_c%0d", c), 1'b0, 32'd2, 1'b0);
        else                  chk_rsp($sformatf("t3_rsp_c%0d", c), 1'b1, 32'd7, 1'b0);
      end
      next_cycle();
    end
    mid();
    check_eq("t3_drained", {31'd0, bus.RspValid}, 32'd0);
    next_cycle();

    // Backpressure: two ops fill the pipe, then Ready drops and the result holds.
    n_acc = 0;
    bus.RspReady = 1'b0;
    for (int c = 0; c < 5; c++) begin
      drive0(1'b1, 32'd1 + n_acc, 32'h10, 3'b010);
      mid();
      check_eq($sformatf("t4_ready0_c%0d", c), {31'd0, bus.Req0Ready}, (c < 2) ? 32'd1 : 32'd0);
      if (c < 2) n_acc++;
      if (c >= 2) begin
        check_eq($sformatf("t4_hold_valid_c%0d", c), {31'd0, bus.RspValid}, 32'd1);
        check_eq($sformatf("t4_hold_result_c%0d", c), bus.RspResult, 32'h11);
      end
      next_cycle();
    end
    drive0(1'b0, 32'd0, 32'd0, 3'b000);
    bus.RspReady = 1'b1;
    mid();
    chk_rsp("t4_first", 1'b0, 32'h11, 1'b0);
    next_cycle();
    mid();
    chk_rsp("t4_second", 1'b0, 32'h12, 1'b0);
    next_cycle();
    mid();
    check_eq("t4_nodup", {31'd0, bus.RspValid}, 32'd0);
    next_cycle();

    // Async reset with two ops in flight.
    bus.RspReady = 1'b0;
    drive0(1'b1, 32'h20, 32'h1, 3'b010);
    next_cycle();
    drive0(1'b1, 32'h30, 32'h1, 3'b010);
    next_cycle();
    drive0(1'b0, 32'd0, 32'd0, 3'b000);
    check_eq("t5_before_rst", {31'd0, bus.RspValid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t5_async_valid", {31'd0, bus.RspValid}, 32'd0);
    check_eq("t5_async_alua", bus.AluA, 32'd0);
    next_cycle();
    rst_n = 1'b1;
    bus.RspReady = 1'b1;
    for (int c = 0; c < 3; c++) begin
      mid();
      check_eq($sformatf("t5_nostale_c%0d", c), {31'd0, bus.RspValid}, 32'd0);
      next_cycle();
    end
    drive0(1'b1, 32'h0000_000F, 32'h0000_00F0, 3'b001);
    drive1(1'b1, 32'h0000_000F, 32'h0000_00F0, 3'b110);
    mid();
    check_eq("t5_ready0", {31'd0, bus.Req0Ready}, 32'd1);
    check_eq("t5_ready1", {31'd0, bus.Req1Ready}, 32'd0);
    next_cycle();
    drive0(1'b0, 32'd0, 32'd0, 3'b000);
    drive1(1'b0, 32'd0, 32'd0, 3'b000);
    next_cycle();
    mid();
    chk_rsp("t5_rsp", 1'b0, 32'h0000_00FF, 1'b0);
    next_cycle();
    next_cycle();

    // OR, AND, then unused code 011 passed straight to the ALU.
    drive0(1'b1, 32'h0000_000F, 32'h0000_00F0, 3'b001);
    next_cycle();
    drive0(1'b1, 32'h0000_000F, 32'h0000_00F0, 3'b000);
    mid();
    check_eq("t6_ready0", {31'd0, bus.Req0Ready}, 32'd1);
    next_cycle();
    drive0(1'b0, 32'd0, 32'd0, 3'b000);
    drive1(1'b1, 32'd5, 32'd3, 3'b011);
    mid();
    check_eq("t6_ready1", {31'd0, bus.Req1Ready}, 32'd1);
    chk_rsp("t6_or", 1'b0, 32'h0000_00FF, 1'b0);
    next_cycle();
    drive1(1'b0, 32'd0, 32'd0, 3'b000);
    mid();
    check_eq("t6_ctrl011", {29'd0, bus.AluControl}, 32'd3);
    chk_rsp("t6_and", 1'b0, 32'd0, 1'b1);
    next_cycle();
    mid();
    chk_rsp("t6_x011", 1'b1, 32'd6, 1'b0);
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
